// File: rtl/b2r_pkg.sv
// Shared definitions for the block-to-row stream converter: read FSM states,
// derived-size helpers and core-mode word / row bit-offset helpers.
package b2r_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;

   function automatic int unsigned f_cw(input int unsigned n);
      return (n > 1) ? 32'($clog2(n)) : 32'd1;
   endfunction

   function automatic int unsigned f_chunk(input int unsigned bs);
      return bs * bs;
   endfunction

   function automatic int unsigned f_slice(input int unsigned col, input int unsigned bs,
                                           input int unsigned nh);
      return col / (bs * nh);
   endfunction

   function automatic int unsigned f_groups(input int unsigned row, input int unsigned bs,
                                            input int unsigned nv);
      return row / (bs * nv);
   endfunction

   function automatic int unsigned f_words(input int unsigned row, input int unsigned col,
                                           input int unsigned bs, input int unsigned nh,
                                           input int unsigned nv);
      return f_slice(col, bs, nh) * f_groups(row, bs, nv);
   endfunction

   function automatic int unsigned f_rpg(input int unsigned bs, input int unsigned nv);
      return bs * nv;
   endfunction

   // Bit offset of element (i, j) of core (v, h) inside one core-mode word
   function automatic int unsigned f_elem_off(input int unsigned v, input int unsigned h,
                                              input int unsigned i, input int unsigned j,
                                              input int unsigned bs, input int unsigned nh,
                                              input int unsigned width);
      return ((v * nh + h) * bs * bs + i * bs + j) * width;
   endfunction

   // Bit offset of column (slice s, core column h, block column j) inside one row
   function automatic int unsigned f_col_off(input int unsigned s, input int unsigned h,
                                             input int unsigned j, input int unsigned bs,
                                             input int unsigned nh, input int unsigned width);
      return ((s * nh + h) * bs + j) * width;
   endfunction

endpackage

// File: rtl/b2r_row_assemble.sv
// Combinational row selector: picks row (v, i) of the current block group
// out of the slice registers and lays it out in natural column order.
module b2r_row_assemble
   import b2r_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned COL         = 64,
   parameter int unsigned BLOCK_SIZE  = 2,
   parameter int unsigned NUM_CORES_H = 2,
   parameter int unsigned NUM_CORES_V = 2,
   localparam int unsigned SLICE  = f_slice(COL, BLOCK_SIZE, NUM_CORES_H),
   localparam int unsigned WORD_W = WIDTH * f_chunk(BLOCK_SIZE) * NUM_CORES_H * NUM_CORES_V,
   localparam int unsigned V_W    = f_cw(NUM_CORES_V),
   localparam int unsigned I_W    = f_cw(BLOCK_SIZE)
) (
   input  logic [WORD_W-1:0]    i_slice [SLICE],
   input  logic [V_W-1:0]       i_v,
   input  logic [I_W-1:0]       i_i,
   output logic [WIDTH*COL-1:0] o_row_c
);

   always_comb begin
      o_row_c = '0;
      for (int vv = 0; vv < int'(NUM_CORES_V); vv++) begin
         for (int ii = 0; ii < int'(BLOCK_SIZE); ii++) begin
            if (i_v == V_W'(vv) && i_i == I_W'(ii)) begin
               for (int s = 0; s < int'(SLICE); s++) begin
                  for (int h = 0; h < int'(NUM_CORES_H); h++) begin
                     for (int j = 0; j < int'(BLOCK_SIZE); j++) begin
                        o_row_c[f_col_off(s, h, j, BLOCK_SIZE, NUM_CORES_H, WIDTH) +: WIDTH] =
                           i_slice[s][f_elem_off(vv, h, ii, j, BLOCK_SIZE, NUM_CORES_H, WIDTH) +: WIDTH];
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/ram_1w1r.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module ram_1w1r #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/b2r_stream_converter.sv
// Block-to-row converter: buffers one matrix of core-mode words and re-emits it
// one row per beat. Define B2R_PINGPONG_EN for a second bank (fill while draining).
module b2r_stream_converter
   import b2r_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned ROW         = 256,
   parameter int unsigned COL         = 64,
   parameter int unsigned BLOCK_SIZE  = 2,
   parameter int unsigned NUM_CORES_H = 2,
   parameter int unsigned NUM_CORES_V = 2,
   localparam int unsigned WORD_W = WIDTH * f_chunk(BLOCK_SIZE) * NUM_CORES_H * NUM_CORES_V,
   localparam int unsigned ROW_W  = f_cw(ROW)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH*COL-1:0] out_data,
   output logic [ROW_W-1:0]     out_row,
   output logic                 out_last,
   output logic                 busy
);

`ifdef B2R_PINGPONG_EN
   localparam int unsigned NBANK    = 2;
   localparam logic        BANK_TGL = 1'b1;
`else
   localparam int unsigned NBANK    = 1;
   localparam logic        BANK_TGL = 1'b0;
`endif

   localparam int unsigned SLICE  = f_slice(COL, BLOCK_SIZE, NUM_CORES_H);
   localparam int unsigned GROUPS = f_groups(ROW, BLOCK_SIZE, NUM_CORES_V);
   localparam int unsigned WORDS  = f_words(ROW, COL, BLOCK_SIZE, NUM_CORES_H, NUM_CORES_V);
   localparam int unsigned DEPTH  = NBANK * WORDS;
   localparam int unsigned AW     = f_cw(DEPTH);
   localparam int unsigned WCNT_W = f_cw(WORDS);
   localparam int unsigned GRP_W  = f_cw(GROUPS);
   localparam int unsigned LCNT_W = f_cw(SLICE + 1);
   localparam int unsigned V_W    = f_cw(NUM_CORES_V);
   localparam int unsigned I_W    = f_cw(BLOCK_SIZE);
   localparam int unsigned DATA_W = WIDTH * COL;

   // Write side
   logic              r_wr_bank, w_wr_bank_nxt;
   logic [WCNT_W-1:0] r_wr_cnt, w_wr_cnt_nxt;
   logic [1:0]        r_full, w_full_nxt, w_set, w_clr;
   logic              w_in_hs;
   logic [AW-1:0]     w_waddr;
   logic              r_busy;

   // Read side
   logic [1:0]        r_state, w_state_nxt;
   logic              r_rd_bank, w_rd_bank_nxt;
   logic [GRP_W-1:0]  r_grp, w_grp_nxt;
   logic [LCNT_W-1:0] r_ld_cnt, w_ld_cnt_nxt, w_ld_idx;
   logic [V_W-1:0]    r_v, w_v_nxt, w_asm_v;
   logic [I_W-1:0]    r_i, w_i_nxt, w_asm_i;
   logic              w_grp_end, w_release;
   logic [AW-1:0]     w_raddr;
   logic [WORD_W-1:0] w_rdata;
   logic [WORD_W-1:0] r_slice [SLICE];
   logic [WORD_W-1:0] w_slice_nxt [SLICE];
   logic [DATA_W-1:0] w_row_c;

   logic              r_out_valid, w_ov_nxt;
   logic [DATA_W-1:0] r_out_data, w_od_nxt;
   logic [ROW_W-1:0]  r_out_row, w_orow_nxt, w_row_inc;
   logic              r_out_last, w_olast_nxt;

   assign in_ready = !r_full[r_wr_bank];
   assign w_in_hs  = in_valid && in_ready;
   assign w_waddr  = AW'(32'(r_wr_bank) * WORDS + 32'(r_wr_cnt));

   always_comb begin
      w_wr_cnt_nxt  = r_wr_cnt;
      w_wr_bank_nxt = r_wr_bank;
      w_set         = '0;
      if (w_in_hs) begin
         if (r_wr_cnt == WCNT_W'(WORDS - 1)) begin
            w_wr_cnt_nxt     = '0;
            w_set[r_wr_bank] = 1'b1;
            w_wr_bank_nxt    = r_wr_bank ^ BANK_TGL;
         end else begin
            w_wr_cnt_nxt = r_wr_cnt + 1'b1;
         end
      end
   end

   // Fill-complete and release may hit different banks in the same cycle
   always_comb begin
      w_clr            = '0;
      w_clr[r_rd_bank] = w_release;
      w_full_nxt       = (r_full | w_set) & ~w_clr;
   end

   ram_1w1r #(
      .DATA_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_in_hs),
      .i_waddr (w_waddr),
      .i_wdata (in_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign w_ld_idx  = (r_ld_cnt < LCNT_W'(SLICE)) ? r_ld_cnt : '0;
   assign w_raddr   = AW'(32'(r_rd_bank) * WORDS + 32'(r_grp) * SLICE + 32'(w_ld_idx));
   assign w_grp_end = (r_v == V_W'(NUM_CORES_V - 1)) && (r_i == I_W'(BLOCK_SIZE - 1));
   assign w_row_inc = (r_out_row == ROW_W'(ROW - 1)) ? '0 : r_out_row + 1'b1;

   // RAM data lands one cycle after its address; slice s arrives at ld_cnt == s+1
   always_comb begin
      w_slice_nxt = r_slice;
      if (r_state == ST_LOAD) begin
         for (int s = 0; s < int'(SLICE); s++) begin
            if (r_ld_cnt == LCNT_W'(s + 1)) w_slice_nxt[s] = w_rdata;
         end
      end
   end

   // Row (v, i) of the next beat: first row of the group while loading
   always_comb begin
      w_asm_v = '0;
      w_asm_i = '0;
      if (r_state == ST_EMIT) begin
         if (r_i == I_W'(BLOCK_SIZE - 1)) begin
            w_asm_v = (r_v == V_W'(NUM_CORES_V - 1)) ? '0 : r_v + 1'b1;
         end else begin
            w_asm_v = r_v;
            w_asm_i = r_i + 1'b1;
         end
      end
   end

   b2r_row_assemble #(
      .WIDTH       (WIDTH),
      .COL         (COL),
      .BLOCK_SIZE  (BLOCK_SIZE),
      .NUM_CORES_H (NUM_CORES_H),
      .NUM_CORES_V (NUM_CORES_V)
   ) u_row (
      .i_slice (w_slice_nxt),
      .i_v     (w_asm_v),
      .i_i     (w_asm_i),
      .o_row_c (w_row_c)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_rd_bank_nxt = r_rd_bank;
      w_grp_nxt     = r_grp;
      w_ld_cnt_nxt  = r_ld_cnt;
      w_v_nxt       = r_v;
      w_i_nxt       = r_i;
      w_release     = 1'b0;
      w_ov_nxt      = r_out_valid;
      w_od_nxt      = r_out_data;
      w_orow_nxt    = r_out_row;
      w_olast_nxt   = r_out_last;
      case (r_state)
         ST_IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_state_nxt  = ST_LOAD;
               w_ld_cnt_nxt = '0;
            end
         end
         ST_LOAD: begin
            if (r_ld_cnt == LCNT_W'(SLICE)) begin
               w_state_nxt  = ST_EMIT;
               w_ld_cnt_nxt = '0;
               w_ov_nxt     = 1'b1;
               w_od_nxt     = w_row_c;
               w_olast_nxt  = (r_out_row == ROW_W'(ROW - 1));
            end else begin
               w_ld_cnt_nxt = r_ld_cnt + 1'b1;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               w_orow_nxt = w_row_inc;
               w_v_nxt    = w_asm_v;
               w_i_nxt    = w_asm_i;
               if (w_grp_end) begin
                  w_ov_nxt    = 1'b0;
                  w_olast_nxt = 1'b0;
                  if (r_grp == GRP_W'(GROUPS - 1)) begin
                     w_grp_nxt     = '0;
                     w_release     = 1'b1;
                     w_rd_bank_nxt = r_rd_bank ^ BANK_TGL;
                     w_state_nxt   = ST_IDLE;
                  end else begin
                     w_grp_nxt   = r_grp + 1'b1;
                     w_state_nxt = ST_LOAD;
                  end
               end else begin
                  w_od_nxt    = w_row_c;
                  w_olast_nxt = (w_row_inc == ROW_W'(ROW - 1));
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_bank   <= 1'b0;
         r_wr_cnt    <= '0;
         r_full      <= '0;
         r_busy      <= 1'b0;
         r_state     <= ST_IDLE;
         r_rd_bank   <= 1'b0;
         r_grp       <= '0;
         r_ld_cnt    <= '0;
         r_v         <= '0;
         r_i         <= '0;
         r_slice     <= '{default: '0};
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_row   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_wr_bank   <= w_wr_bank_nxt;
         r_wr_cnt    <= w_wr_cnt_nxt;
         r_full      <= w_full_nxt;
         r_busy      <= (|w_full_nxt) || (w_wr_cnt_nxt != '0);
         r_state     <= w_state_nxt;
         r_rd_bank   <= w_rd_bank_nxt;
         r_grp       <= w_grp_nxt;
         r_ld_cnt    <= w_ld_cnt_nxt;
         r_v         <= w_v_nxt;
         r_i         <= w_i_nxt;
         r_slice     <= w_slice_nxt;
         r_out_valid <= w_ov_nxt;
         r_out_data  <= w_od_nxt;
         r_out_row   <= w_orow_nxt;
         r_out_last  <= w_olast_nxt;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_row   = r_out_row;
   assign out_last  = r_out_last;
   assign busy      = r_busy;

endmodule

// File: tb/tb_b2r_stream_converter.sv
// Scoreboard bench for b2r_stream_converter (8x8 matrix, 2x2 blocks, 2x2 cores).
module tb_b2r_stream_converter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned ROW   = 8;
   localparam int unsigned COL   = 8;
   localparam int unsigned BS    = 2;
   localparam int unsigned NH    = 2;
   localparam int unsigned NV    = 2;
   localparam int unsigned WW    = WIDTH * BS * BS * NH * NV;
   localparam int unsigned DW    = WIDTH * COL;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [2:0]    row;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [2:0]    out_row;
   logic          out_last;
   logic          busy;

   beat_t q[$];
   int    nchk = 0;
   int    nerr = 0;
   int    cyc = 0;
   int    hs_edge = 0;
   int    last_edge = -1;
   int    rdy_mode = 0;
   int    wt[8];
   int    he[8];
   bit    arm_first = 1'b0;
   bit    busy_chk_en = 1'b0;
   bit    busy_pend = 1'b0;

   b2r_stream_converter #(
      .WIDTH (WIDTH), .ROW (ROW), .COL (COL),
      .BLOCK_SIZE (BS), .NUM_CORES_H (NH), .NUM_CORES_V (NV)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .out_row (out_row), .out_last (out_last), .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Core-mode word w of a matrix whose element (r,c) = r*8+c+off
   function automatic logic [WW-1:0] mk_word(input int w, input int off);
      logic [WW-1:0] d;
      int br, bc, r, c;
      d  = '0;
      br = w / 2;
      bc = w % 2;
      for (int v = 0; v < 2; v++)
         for (int h = 0; h < 2; h++)
            for (int i = 0; i < 2; i++)
               for (int j = 0; j < 2; j++) begin
                  r = (br * 2 + v) * 2 + i;
                  c = (bc * 2 + h) * 2 + j;
                  d[((v * 2 + h) * 4 + i * 2 + j) * 8 +: 8] = 8'((r * 8 + c + off) % 256);
               end
      return d;
   endfunction

   task automatic push_matrix(input int off);
      beat_t b;
      for (int r = 0; r < 8; r++) begin
         b = '0;
         for (int c = 0; c < 8; c++) b.data[c*8 +: 8] = 8'((r * 8 + c + off) % 256);
         b.row  = 3'(r);
         b.last = (r == 7);
         q.push_back(b);
      end
   endtask

   task automatic send_word(input logic [WW-1:0] d, output int waits);
      bit hs;
      hs       = 1'b0;
      waits    = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!hs && waits < 300) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
         if (!hs) waits++;
      end
      in_valid = 1'b0;
      if (!hs) begin
         nchk++;
         nerr++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waits);
      end else begin
         hs_edge = cyc;
      end
   endtask

   task automatic send_matrix(input int off, input bit bub, input int base);
      for (int w = 0; w < 4; w++) begin
         if (bub) begin
            for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
               @(posedge clk);
               #1;
            end
         end
         send_word(mk_word(w, off), wt[base+w]);
         he[base+w] = hs_edge;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         nchk++;
         nerr++;
         $display("FAIL drain_timeout: %0d beats still expected, busy=%0b", q.size(), busy);
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Consumer ready: constant 1, or the repeating pattern 1,0,0,1
   initial begin
      logic [3:0] pat;
      int k;
      pat = 4'b1001;
      k   = 0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = (rdy_mode == 0) ? 1'b1 : pat[k%4];
         k++;
      end
   end

   // Monitor: compares every presented beat against the scoreboard head
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy_pend) begin
            chk("busy_after_last", busy, 0);
            busy_pend = 1'b0;
         end
         if (out_valid) begin
            if (arm_first) begin
               chk("first_valid_latency", cyc - hs_edge, 4);
               arm_first = 1'b0;
            end
            if (q.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_beat: row %0d data %0h with empty scoreboard", out_row, out_data);
            end else begin
               chk(out_ready ? "beat" : "beat_stall", {out_data, out_row, out_last}, q[0]);
               if (out_ready) begin
                  if (q[0].last) begin
                     if (last_edge < 0) last_edge = cyc + 1;
                     if (busy_chk_en) busy_pend = 1'b1;
                  end
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_w;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single matrix, consumer always ready
      rdy_mode    = 0;
      busy_chk_en = 1'b1;
      push_matrix(0);
      send_matrix(0, 1'b0, 0);
      arm_first = 1'b1;
      wait_drain();

      // Backpressure 1,0,0,1
      rdy_mode = 1;
      push_matrix(0);
      send_matrix(0, 1'b0, 0);
      wait_drain();

      // Two matrices back to back
      rdy_mode    = 0;
      busy_chk_en = 1'b0;
      last_edge   = -1;
      push_matrix(0);
      push_matrix(64);
      send_matrix(0, 1'b0, 0);
      send_matrix(64, 1'b0, 4);
`ifdef B2R_PINGPONG_EN
      for (int k = 0; k < 8; k++) chk("pp_ready_wait", wt[k], 0);
`else
      for (int k = 0; k < 4; k++) chk("np_ready_wait", wt[k], 0);
      chk("np_stalled_word4", (wt[4] > 0), 1);
      chk("np_resume_edge", he[4], last_edge + 1);
`endif
      wait_drain();

      // Reset after two words discards the partial fill
      busy_chk_en = 1'b1;
      send_word(mk_word(0, 0), n_w);
      send_word(mk_word(1, 0), n_w);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      push_matrix(128);
      send_matrix(128, 1'b0, 0);
      wait_drain();

      // Input bubbles
      push_matrix(0);
      send_matrix(0, 1'b1, 0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
